// File: rtl/synth_voice_pkg.sv
// Shared constants, types and FSM states for the voice allocator slice.
package synth_voice_pkg;

    localparam int NUM_VOICES = 8;
    localparam int NOTE_W     = 7;
    localparam int VEL_W      = 7;

    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [VEL_W-1:0]  vel_t;
    typedef logic [2:0]        voice_idx_t;
    typedef logic [2:0]        rank_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        EMIT   = 2'd2
    } state_t;

    // One-hot slot mask for a slot index.
    function automatic logic [NUM_VOICES-1:0] slot_mask(input voice_idx_t idx);
        return {{(NUM_VOICES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/voice_find.sv
// Combinational slot lookup: note match, lowest free slot and oldest slot.
// The oldest-slot search exists only when VOICE_STEAL_EN is defined; otherwise
// old_hit is tied low so a full pool with no match drops the note-on.
module voice_find
    import synth_voice_pkg::*;
(
    input  logic [NUM_VOICES-1:0]             active,
    input  logic [NUM_VOICES-1:0][NOTE_W-1:0] slot_note,
    input  logic [NOTE_W-1:0]                 key,
`ifdef VOICE_STEAL_EN
    input  logic [NUM_VOICES-1:0][2:0]        rank,
`endif
    output logic                              match_hit,
    output logic [2:0]                        match_idx,
    output logic                              free_hit,
    output logic [2:0]                        free_idx,
    output logic                              old_hit,
    output logic [2:0]                        old_idx
);

    // Scan from the top slot down so the lowest matching index wins.
    always_comb begin
        match_hit = 1'b0;
        match_idx = 3'd0;
        free_hit  = 1'b0;
        free_idx  = 3'd0;
        old_hit   = 1'b0;
        old_idx   = 3'd0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            match_hit = match_hit | (active[i] && (slot_note[i] == key));
            match_idx = (active[i] && (slot_note[i] == key)) ? 3'(i) : match_idx;
            free_hit  = free_hit | !active[i];
            free_idx  = !active[i] ? 3'(i) : free_idx;
`ifdef VOICE_STEAL_EN
            old_hit   = old_hit | (rank[i] == 3'd7);
            old_idx   = (rank[i] == 3'd7) ? 3'(i) : old_idx;
`endif
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: accepts note events, tracks 8 voice slots, emits one
// registered demux command per event (IDLE -> SEARCH -> EMIT).
// Optional macro VOICE_STEAL_EN: steal the oldest voice when the pool is full.
module voice_allocator
    import synth_voice_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [NOTE_W-1:0]     ev_note,
    input  logic [VEL_W-1:0]      ev_vel,
    output logic                  out_valid,
    output logic [2:0]            out_sel,
    output logic [NOTE_W-1:0]     out_note,
    output logic [VEL_W-1:0]      out_vel,
    output logic                  out_gate,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  ev_dropped
);

    state_t                            state_r, state_s;
    logic                              on_r;
    note_t                             note_r;
    vel_t                              vel_r;
    logic                              go_r, go_s;
    voice_idx_t                        sel_r, sel_s;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] slot_note_r;
    logic [NUM_VOICES-1:0][2:0]        rank_r;
    logic                              accept_s;
    logic                              match_hit_s, free_hit_s, old_hit_s;
    logic [2:0]                        match_idx_s, free_idx_s, old_idx_s;

    assign accept_s = ev_valid && ev_ready;

    voice_find u_find (
        .active    (voice_active),
        .slot_note (slot_note_r),
        .key       (note_r),
`ifdef VOICE_STEAL_EN
        .rank      (rank_r),
`endif
        .match_hit (match_hit_s),
        .match_idx (match_idx_s),
        .free_hit  (free_hit_s),
        .free_idx  (free_idx_s),
        .old_hit   (old_hit_s),
        .old_idx   (old_idx_s)
    );

    // Next-state logic for the three-phase event pipeline.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SEARCH;
                end else begin
                    state_s = IDLE;
                end
            end
            SEARCH:  state_s = EMIT;
            EMIT:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Slot choice: note-on prefers match, then free, then oldest; note-off needs a match.
    always_comb begin
        go_s  = 1'b0;
        sel_s = 3'd0;
        if (on_r) begin
            if (match_hit_s) begin
                go_s  = 1'b1;
                sel_s = match_idx_s;
            end else if (free_hit_s) begin
                go_s  = 1'b1;
                sel_s = free_idx_s;
            end else begin
                go_s  = old_hit_s;
                sel_s = old_idx_s;
            end
        end else begin
            go_s  = match_hit_s;
            sel_s = match_idx_s;
        end
    end

    // State register; ev_ready is registered and high exactly while in IDLE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r  <= IDLE;
            ev_ready <= 1'b1;
        end else begin
            state_r  <= state_s;
            ev_ready <= (state_s == IDLE);
        end
    end

    // Latch the accepted event; a zero-velocity note-on becomes a note-off.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            on_r   <= 1'b0;
            note_r <= 7'd0;
            vel_r  <= 7'd0;
        end else if (accept_s) begin
            on_r   <= ev_on && (ev_vel != 7'd0);
            note_r <= ev_note;
            vel_r  <= ev_vel;
        end
    end

    // Register the lookup decision during SEARCH.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            go_r  <= 1'b0;
            sel_r <= 3'd0;
        end else if (state_r == SEARCH) begin
            go_r  <= go_s;
            sel_r <= sel_s;
        end
    end

    // EMIT: pulse the command or drop, and commit slot occupancy, notes and age ranks.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid    <= 1'b0;
            out_sel      <= 3'd0;
            out_note     <= 7'd0;
            out_vel      <= 7'd0;
            out_gate     <= 1'b0;
            ev_dropped   <= 1'b0;
            voice_active <= 8'd0;
            slot_note_r  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_r[i] <= 3'(i);
            end
        end else begin
            out_valid  <= 1'b0;
            ev_dropped <= 1'b0;
            if (state_r == EMIT) begin
                if (go_r) begin
                    out_valid <= 1'b1;
                    out_sel   <= sel_r;
                    out_gate  <= on_r;
                    if (on_r) begin
                        out_note            <= note_r;
                        out_vel             <= vel_r;
                        voice_active        <= voice_active | slot_mask(sel_r);
                        slot_note_r[sel_r]  <= note_r;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (3'(i) == sel_r) begin
                                rank_r[i] <= 3'd0;
                            end else if (rank_r[i] < rank_r[sel_r]) begin
                                rank_r[i] <= rank_r[i] + 3'd1;
                            end
                        end
                    end else begin
                        out_note     <= slot_note_r[sel_r];
                        out_vel      <= 7'd0;
                        voice_active <= voice_active & ~slot_mask(sel_r);
                    end
                end else begin
                    ev_dropped <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator with a queue-based reference model.
module tb_voice_allocator;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic       ev_on = 1'b0;
    logic [6:0] ev_note = 7'd0;
    logic [6:0] ev_vel = 7'd0;
    logic       out_valid;
    logic [2:0] out_sel;
    logic [6:0] out_note;
    logic [6:0] out_vel;
    logic       out_gate;
    logic [7:0] voice_active;
    logic       ev_dropped;

    voice_allocator dut (
        .Clk(Clk), .Reset(Reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_note(ev_note), .ev_vel(ev_vel),
        .out_valid(out_valid), .out_sel(out_sel), .out_note(out_note),
        .out_vel(out_vel), .out_gate(out_gate), .voice_active(voice_active),
        .ev_dropped(ev_dropped)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    // Reference model: per-slot flags/notes plus an age list (front = newest).
    logic       m_active [8];
    logic [6:0] m_note [8];
    int         m_order [$];

    // Expected outcome of the latest event.
    logic       e_valid, e_drop, e_gate;
    logic [2:0] e_sel;
    logic [6:0] e_note, e_vel;
    logic [7:0] e_active;

    // Observed outcome of the latest event.
    logic       o_timeout, o_valid, o_drop, o_gate;
    int         o_k, o_pulses;
    logic [2:0] o_sel;
    logic [6:0] o_note, o_vel;
    logic [7:0] o_active;

    task model_reset;
        m_order = {};
        for (int i = 0; i < 8; i++) begin
            m_active[i] = 1'b0;
            m_note[i] = 7'd0;
            m_order.push_back(i);
        end
    endtask

    task model_event(input logic on, input logic [6:0] note, input logic [6:0] vel);
        int s;
        s = -1;
        e_valid = 1'b0; e_drop = 1'b0; e_gate = 1'b0;
        e_sel = 3'd0; e_note = 7'd0; e_vel = 7'd0;
        for (int i = 0; i < 8; i++)
            if (s < 0 && m_active[i] && m_note[i] == note) s = i;
        if (on && vel != 7'd0) begin
            for (int i = 0; i < 8; i++)
                if (s < 0 && !m_active[i]) s = i;
`ifdef VOICE_STEAL_EN
            if (s < 0) s = m_order[7];
`endif
            if (s >= 0) begin
                e_valid = 1'b1; e_sel = 3'(s); e_note = note; e_vel = vel; e_gate = 1'b1;
                m_active[s] = 1'b1;
                m_note[s] = note;
                for (int j = 0; j < m_order.size(); j++)
                    if (m_order[j] == s) begin
                        m_order.delete(j);
                        break;
                    end
                m_order.push_front(s);
            end else begin
                e_drop = 1'b1;
            end
        end else begin
            if (s >= 0) begin
                e_valid = 1'b1; e_sel = 3'(s); e_note = m_note[s]; e_vel = 7'd0; e_gate = 1'b0;
                m_active[s] = 1'b0;
            end else begin
                e_drop = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) e_active[i] = m_active[i];
    endtask

    // Offer one event, then watch four cycles for the result pulse.
    task drive_event(input logic on, input logic [6:0] note, input logic [6:0] vel);
        int w;
        o_timeout = 1'b0; o_k = 0; o_pulses = 0;
        o_valid = 1'b0; o_drop = 1'b0; o_gate = 1'b0;
        o_sel = 3'd0; o_note = 7'd0; o_vel = 7'd0; o_active = 8'd0;
        w = 0;
        @(negedge Clk);
        while (!ev_ready && w < 20) begin
            @(negedge Clk);
            w++;
        end
        if (!ev_ready) o_timeout = 1'b1;
        ev_valid = 1'b1; ev_on = on; ev_note = note; ev_vel = vel;
        @(posedge Clk);
        #1 ev_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            if (out_valid || ev_dropped) begin
                o_pulses++;
                if (o_k == 0) begin
                    o_k = k; o_valid = out_valid; o_drop = ev_dropped;
                    o_sel = out_sel; o_note = out_note; o_vel = out_vel;
                    o_gate = out_gate; o_active = voice_active;
                end
            end
        end
    endtask

    task ev(input logic on, input logic [6:0] note, input logic [6:0] vel);
        model_event(on, note, vel);
        drive_event(on, note, vel);
    endtask

    task do_reset;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task test_reset;
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        total++;
        if ({out_valid, out_sel, out_note, out_vel, out_gate, voice_active, ev_dropped} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {out_valid, out_sel, out_note, out_vel, out_gate, voice_active, ev_dropped});
        end
        total++;
        if (ev_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ev_ready); end
        Reset = 1'b0;
        model_reset();
    endtask

    task test_basic;
        do_reset();
        ev(1'b1, 7'd60, 7'd100);
        total++;
        if (o_k !== 3) begin bad++; $display("FAIL basic_latency: got cycle %0d want 3", o_k); end
        total++;
        if ({o_valid, o_sel, o_gate, o_active, o_note, o_vel} !== {1'b1, 3'd0, 1'b1, 8'h01, 7'd60, 7'd100}) begin
            bad++;
            $display("FAIL basic_cmd: got v=%b sel=%0d gate=%b act=%h note=%0d vel=%0d want 1 0 1 01 60 100",
                     o_valid, o_sel, o_gate, o_active, o_note, o_vel);
        end
    endtask

    task test_release;
        do_reset();
        ev(1'b1, 7'd60, 7'd90);
        ev(1'b1, 7'd62, 7'd91);
        ev(1'b1, 7'd64, 7'd92);
        ev(1'b0, 7'd62, 7'd33);
        total++;
        if ({o_valid, o_sel, o_vel, o_gate, o_active, o_note} !== {1'b1, 3'd1, 7'd0, 1'b0, 8'h05, 7'd62}) begin
            bad++;
            $display("FAIL release_cmd: got v=%b sel=%0d vel=%0d gate=%b act=%h note=%0d want 1 1 0 0 05 62",
                     o_valid, o_sel, o_vel, o_gate, o_active, o_note);
        end
    endtask

    task test_retrigger;
        do_reset();
        ev(1'b1, 7'd60, 7'd90);
        ev(1'b1, 7'd60, 7'd110);
        total++;
        if ({o_valid, o_sel, o_gate, o_active, o_vel} !== {1'b1, 3'd0, 1'b1, 8'h01, 7'd110}) begin
            bad++;
            $display("FAIL retrigger_cmd: got v=%b sel=%0d gate=%b act=%h vel=%0d want 1 0 1 01 110",
                     o_valid, o_sel, o_gate, o_active, o_vel);
        end
        ev(1'b1, 7'd62, 7'd50);
        total++;
        if ({o_sel, o_active} !== {3'd1, 8'h03}) begin
            bad++;
            $display("FAIL retrigger_next: got sel=%0d act=%h want 1 03", o_sel, o_active);
        end
    endtask

    task test_full;
        do_reset();
        for (int n = 0; n < 8; n++) ev(1'b1, 7'(60 + n), 7'd64);
        total++;
        if ({o_sel, o_active} !== {3'd7, 8'hFF}) begin
            bad++;
            $display("FAIL full_fill: got sel=%0d act=%h want 7 ff", o_sel, o_active);
        end
        ev(1'b1, 7'd70, 7'd99);
`ifdef VOICE_STEAL_EN
        total++;
        if ({o_valid, o_drop, o_sel, o_note, o_active} !== {1'b1, 1'b0, 3'd0, 7'd70, 8'hFF}) begin
            bad++;
            $display("FAIL full_steal: got v=%b drop=%b sel=%0d note=%0d act=%h want 1 0 0 70 ff",
                     o_valid, o_drop, o_sel, o_note, o_active);
        end
`else
        total++;
        if ({o_valid, o_drop, o_active, o_pulses[3:0]} !== {1'b0, 1'b1, 8'hFF, 4'd1}) begin
            bad++;
            $display("FAIL full_drop: got v=%b drop=%b act=%h pulses=%0d want 0 1 ff 1",
                     o_valid, o_drop, o_active, o_pulses);
        end
`endif
    endtask

    task test_dropped_off;
        do_reset();
        ev(1'b0, 7'd90, 7'd0);
        total++;
        if ({o_valid, o_drop, o_active} !== {1'b0, 1'b1, 8'h00} || o_k !== 3) begin
            bad++;
            $display("FAIL off_nomatch: got v=%b drop=%b act=%h cycle=%0d want 0 1 00 3", o_valid, o_drop, o_active, o_k);
        end
        ev(1'b1, 7'd60, 7'd80);
        ev(1'b1, 7'd60, 7'd0);
        total++;
        if ({o_valid, o_sel, o_gate, o_vel, o_note, o_active} !== {1'b1, 3'd0, 1'b0, 7'd0, 7'd60, 8'h00}) begin
            bad++;
            $display("FAIL vel0_release: got v=%b sel=%0d gate=%b vel=%0d note=%0d act=%h want 1 0 0 0 60 00",
                     o_valid, o_sel, o_gate, o_vel, o_note, o_active);
        end
    endtask

    task test_reset_mid;
        int pulses;
        int w;
        do_reset();
        ev(1'b1, 7'd60, 7'd1);
        ev(1'b1, 7'd61, 7'd1);
        w = 0;
        @(negedge Clk);
        while (!ev_ready && w < 20) begin @(negedge Clk); w++; end
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd62; ev_vel = 7'd50;
        @(posedge Clk);
        #1 ev_valid = 1'b0;
        Reset = 1'b1;
        #1;
        total++;
        if ({ev_ready, voice_active, out_valid} !== {1'b1, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL midreset_immediate: got ready=%b act=%h v=%b want 1 00 0", ev_ready, voice_active, out_valid);
        end
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            if (out_valid || ev_dropped) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL midreset_nopulse: got %0d pulses want 0", pulses); end
        ev(1'b1, 7'd62, 7'd50);
        total++;
        if ({o_valid, o_sel, o_active} !== {1'b1, 3'd0, 8'h01}) begin
            bad++;
            $display("FAIL midreset_next: got v=%b sel=%0d act=%h want 1 0 01", o_valid, o_sel, o_active);
        end
    endtask

    task test_random;
        logic       on;
        logic [6:0] note, vel;
        do_reset();
        for (int n = 0; n < 150; n++) begin
            on = ($urandom % 10) < 7;
            note = 7'(60 + ($urandom % 10));
            vel = (($urandom % 6) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            ev(on, note, vel);
            total++;
            if (o_timeout || o_k !== 3 || o_pulses !== 1 || o_valid !== e_valid || o_drop !== e_drop || o_active !== e_active) begin
                bad++;
                $display("FAIL rand_handshake[%0d]: got to=%b cyc=%0d n=%0d v=%b d=%b act=%h want 0 3 1 %b %b %h",
                         n, o_timeout, o_k, o_pulses, o_valid, o_drop, o_active, e_valid, e_drop, e_active);
            end
            if (e_valid) begin
                total++;
                if ({o_sel, o_note, o_vel, o_gate} !== {e_sel, e_note, e_vel, e_gate}) begin
                    bad++;
                    $display("FAIL rand_cmd[%0d]: got sel=%0d note=%0d vel=%0d gate=%b want %0d %0d %0d %b",
                             n, o_sel, o_note, o_vel, o_gate, e_sel, e_note, e_vel, e_gate);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_release();
        test_retrigger();
        test_full();
        test_dropped_off();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
